// File: rtl/prei_ctu_sched_pkg.sv
// rtl/prei_ctu_sched_pkg.sv - shared widths and state encoding for the pre-intra CTU scheduler
package prei_ctu_sched_pkg;

    // Frame-geometry widths used by the encoder build
    localparam int PIC_X_WIDTH_DEF = 8;
    localparam int PIC_Y_WIDTH_DEF = 8;
    localparam int QP_WIDTH        = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_t;

endpackage

// File: rtl/prei_qp_fifo.sv
// rtl/prei_qp_fifo.sv - small synchronous FIFO holding {qp, x, y} per finished CTU
module prei_qp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head reads as zero while empty so the consumer-facing outputs are clean after reset
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prei_ctu_sched.sv
// rtl/prei_ctu_sched.sv - raster CTU walker driving pre-intra start/done and buffering per-CTU QP
module prei_ctu_sched
    import prei_ctu_sched_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int PIC_X_WIDTH = PIC_X_WIDTH_DEF,
    parameter int PIC_Y_WIDTH = PIC_Y_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   frame_start_i,
    input  logic [PIC_X_WIDTH-1:0] pic_w_ctu_i,
    input  logic [PIC_Y_WIDTH-1:0] pic_h_ctu_i,
    output logic                   prei_start_o,
    input  logic                   prei_done_i,
    output logic [PIC_X_WIDTH-1:0] rc_ctu_x_o,
    output logic [PIC_Y_WIDTH-1:0] rc_ctu_y_o,
    input  logic [QP_WIDTH-1:0]    rc_qp_i,
    output logic                   qp_valid_o,
    output logic [QP_WIDTH-1:0]    qp_data_o,
    output logic [PIC_X_WIDTH-1:0] qp_x_o,
    output logic [PIC_Y_WIDTH-1:0] qp_y_o,
    input  logic                   qp_ready_i,
    output logic                   busy_o,
    output logic                   frame_done_o
);

    localparam int EW = QP_WIDTH + PIC_X_WIDTH + PIC_Y_WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;

    sched_state_t           state;
    sched_state_t           state_nxt;
    logic [PIC_X_WIDTH-1:0] pic_w;
    logic [PIC_Y_WIDTH-1:0] pic_h;
    logic [PIC_X_WIDTH-1:0] ctu_x;
    logic [PIC_Y_WIDTH-1:0] ctu_y;
    logic                   last_x;
    logic                   last_ctu;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [EW-1:0]          fifo_head;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   frame_done_set;
    logic                   frame_done_q;
    logic                   unused_fifo_count;

    assign last_x   = (ctu_x == pic_w - PIC_X_WIDTH'(1));
    assign last_ctu = last_x && (ctu_y == pic_h - PIC_Y_WIDTH'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        prei_start_o   = 1'b0;
        fifo_push      = 1'b0;
        frame_done_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start_i) begin
                    if ((pic_w_ctu_i == '0) || (pic_h_ctu_i == '0)) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // A free slot is reserved before issuing so the later push can never overflow
                if (!fifo_full) begin
                    prei_start_o = 1'b1;
                    state_nxt    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (prei_done_i) begin
                    fifo_push = 1'b1;
                    state_nxt = last_ctu ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    frame_done_set = 1'b1;
                    state_nxt      = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pic_w        <= '0;
            pic_h        <= '0;
            ctu_x        <= '0;
            ctu_y        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_done_set;
            if ((state == ST_IDLE) && frame_start_i) begin
                pic_w <= pic_w_ctu_i;
                pic_h <= pic_h_ctu_i;
                ctu_x <= '0;
                ctu_y <= '0;
            end else if ((state == ST_WAIT) && prei_done_i && !last_ctu) begin
                if (last_x) begin
                    ctu_x <= '0;
                    ctu_y <= ctu_y + PIC_Y_WIDTH'(1);
                end else begin
                    ctu_x <= ctu_x + PIC_X_WIDTH'(1);
                end
            end
        end
    end

    assign fifo_pop = qp_ready_i && !fifo_empty;

    prei_qp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_qp_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (fifo_push),
        .push_data ({rc_qp_i, ctu_x, ctu_y}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign unused_fifo_count = ^fifo_count;

    assign rc_ctu_x_o   = ctu_x;
    assign rc_ctu_y_o   = ctu_y;
    assign qp_valid_o   = !fifo_empty;
    assign qp_data_o    = fifo_head[EW-1 -: QP_WIDTH];
    assign qp_x_o       = fifo_head[PIC_Y_WIDTH +: PIC_X_WIDTH];
    assign qp_y_o       = fifo_head[PIC_Y_WIDTH-1:0];
    assign busy_o       = (state != ST_IDLE);
    assign frame_done_o = frame_done_q;

endmodule
